slot_config_ctrl: RTL and testbench

- Owns the MSX slot configuration consumed by the slot/page decoder.
- Holds the primary slot register (I/O port A8h, PPI port A image) and the secondary slot registers (memory FFFFh) for expanded primary slots.
- Produces the 8-bit primary map, a configuration-valid flag and the sub-slot select for the current page.
- Bus writes are edge-detected in the clk domain so each Z80 write cycle commits exactly once.

---
 rtl/slot_cfg_pkg.sv | 14 +
 rtl/bus_wr_edge.sv | 27 ++
 rtl/slot_config_ctrl.sv | 86 ++++++++
 tb/tb_slot_config_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slot_cfg_pkg.sv
// Shared types and constants for the MSX slot configuration block.
package slot_cfg_pkg;

  localparam logic [7:0]  IO_PORT_DFLT = 8'hA8;
  localparam logic [15:0] SSR_ADDR     = 16'hFFFF;

  typedef logic [1:0] slot_t;

  // Pull the 2-bit field for a 16 KiB page out of a slot map byte.
  function automatic slot_t page_field(input logic [7:0] map, input logic [1:0] page);
    return map[{page, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/bus_wr_edge.sv
// Turns a Z80 wr_n low phase into a single-cycle write strobe in the clk domain.
module bus_wr_edge (
  input  logic clk,
  input  logic reset,
  input  logic wr_n,
  output logic wstb
);

  logic wr_prev;
  logic armed;

  // armed stays low after reset until wr_n is seen high, so a write already
  // in progress when reset is released cannot produce a strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_prev <= 1'b0;
      armed   <= 1'b0;
    end else begin
      wr_prev <= ~wr_n;
      if (wr_n)
        armed <= 1'b1;
    end
  end

  assign wstb = armed & ~wr_n & ~wr_prev;

endmodule

// File: rtl/slot_config_ctrl.sv
// Primary (port A8h) and secondary (FFFFh) slot registers with page decode and read-back.
module slot_config_ctrl
  import slot_cfg_pkg::*;
#(
  parameter logic [3:0] EXPANDED = 4'b1000,
  parameter logic [7:0] PRIM_RST = 8'h00,
  parameter logic [7:0] IO_PORT  = IO_PORT_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] addr,
  input  logic [7:0]  data_in,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        m1_n,
  input  logic        rd_n,
  input  logic        wr_n,
  output logic [7:0]  prim_slot,
  output logic        cfg_valid,
  output logic [1:0]  sub_slot,
  output logic [7:0]  data_out,
  output logic        data_oe
);

  logic       wstb;
  logic [7:0] sec_reg [4];
  slot_t      ssr_slot;
  slot_t      cur_slot;
  logic [1:0] page;
  logic       io_sel;
  logic       ssr_sel;
  logic       io_wr;
  logic       ssr_wr;

  bus_wr_edge u_wr_edge (
    .clk   (clk),
    .reset (reset),
    .wr_n  (wr_n),
    .wstb  (wstb)
  );

  assign ssr_slot = prim_slot[7:6];
  assign page     = addr[15:14];

  // iorq_n gates the memory decode so an illegal iorq+mreq cycle only acts as I/O.
  assign io_sel  = ~iorq_n & m1_n & (addr[7:0] == IO_PORT);
  assign ssr_sel = ~mreq_n & iorq_n & (addr == SSR_ADDR) & EXPANDED[ssr_slot];
  assign io_wr   = wstb & io_sel;
  assign ssr_wr  = wstb & ssr_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prim_slot <= PRIM_RST;
      cfg_valid <= 1'b0;
      for (int unsigned i = 0; i < 4; i++)
        sec_reg[i] <= '0;
    end else if (io_wr) begin
      prim_slot <= data_in;
      cfg_valid <= 1'b1;
    end else if (ssr_wr) begin
      sec_reg[ssr_slot] <= data_in;
    end
  end

  always_comb begin
    cur_slot = '0;
    sub_slot = '0;
    if (cfg_valid)
      cur_slot = page_field(prim_slot, page);
    if (EXPANDED[cur_slot])
      sub_slot = page_field(sec_reg[cur_slot], page);
  end

  always_comb begin
    data_oe  = 1'b0;
    data_out = '0;
    if (io_sel && !rd_n) begin
      data_oe  = 1'b1;
      data_out = prim_slot;
    end else if (ssr_sel && !rd_n) begin
      data_oe  = 1'b1;
      data_out = ~sec_reg[ssr_slot];
    end
  end

endmodule

// File: tb/tb_slot_config_ctrl.sv
// Scoreboard bench for slot_config_ctrl; a second instance covers the iorq/mreq priority case.
module tb_slot_config_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] addr;
  logic [7:0]  data_in;
  logic        mreq_n, iorq_n, m1_n, rd_n, wr_n;

  logic [7:0]  prim_slot, data_out;
  logic        cfg_valid, data_oe;
  logic [1:0]  sub_slot;

  logic [7:0]  prim_slot2, data_out2;
  logic        cfg_valid2, data_oe2;
  logic [1:0]  sub_slot2;

  always #5 clk = ~clk;

  slot_config_ctrl #(
    .EXPANDED (4'b1000),
    .PRIM_RST (8'h00),
    .IO_PORT  (8'hA8)
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .data_in   (data_in),
    .mreq_n    (mreq_n),
    .iorq_n    (iorq_n),
    .m1_n      (m1_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .prim_slot (prim_slot),
    .cfg_valid (cfg_valid),
    .sub_slot  (sub_slot),
    .data_out  (data_out),
    .data_oe   (data_oe)
  );

  // Port FFh with every slot expanded, so address FFFFh hits both decodes.
  slot_config_ctrl #(
    .EXPANDED (4'b1111),
    .PRIM_RST (8'h00),
    .IO_PORT  (8'hFF)
  ) u_dut2 (
    .clk       (clk),
    .reset     (reset),
    .addr      (addr),
    .data_in   (data_in),
    .mreq_n    (mreq_n),
    .iorq_n    (iorq_n),
    .m1_n      (m1_n),
    .rd_n      (rd_n),
    .wr_n      (wr_n),
    .prim_slot (prim_slot2),
    .cfg_valid (cfg_valid2),
    .sub_slot  (sub_slot2),
    .data_out  (data_out2),
    .data_oe   (data_oe2)
  );

  typedef enum {O_PRIM, O_CFG, O_SUB, O_DOUT, O_DOE, O_PRIM2, O_DOUT2, O_DOE2} obs_e;
  typedef struct {
    obs_e       what;
    string      tag;
    logic [7:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] observe(input obs_e w);
    case (w)
      O_PRIM:  return prim_slot;
      O_CFG:   return {7'd0, cfg_valid};
      O_SUB:   return {6'd0, sub_slot};
      O_DOUT:  return data_out;
      O_DOE:   return {7'd0, data_oe};
      O_PRIM2: return prim_slot2;
      O_DOUT2: return data_out2;
      O_DOE2:  return {7'd0, data_oe2};
      default: return 8'hXX;
    endcase
  endfunction

  task automatic want(input obs_e w, input string tag, input logic [7:0] e);
    exp_t x;
    x.what = w;
    x.tag  = tag;
    x.exp  = e;
    sb.push_back(x);
  endtask

  // Called just after a falling edge; outputs are compared 1 ns later.
  task automatic settle_check();
    exp_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, observe(e.what), e.exp);
    end
  endtask

  task automatic idle();
    addr = '0; data_in = '0;
    mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic io_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; iorq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    idle();
  endtask

  task automatic mem_wr(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; data_in = d; mreq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    idle();
  endtask

  task automatic mem_rd(input logic [15:0] a);
    @(negedge clk);
    addr = a; mreq_n = 1'b0; rd_n = 1'b0;
  endtask

  logic [15:0] pg_addr [4] = '{16'h0000, 16'h4000, 16'h8000, 16'hC000};
  logic [7:0]  sub_c0  [4] = '{8'd0, 8'd0, 8'd0, 8'd0};
  logic [7:0]  sub_ff  [4] = '{8'd3, 8'd2, 8'd1, 8'd0};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state and port read-back
    @(negedge clk);
    addr = 16'h00A8; iorq_n = 1'b0; rd_n = 1'b0;
    want(O_DOE,  "rst_io_oe",   8'h01);
    want(O_DOUT, "rst_io_data", 8'h00);
    want(O_CFG,  "rst_cfg",     8'h00);
    settle_check();
    idle();
    want(O_SUB, "rst_sub0", 8'h00);
    settle_check();

    // Held write strobe commits exactly once, one cycle after the edge
    @(negedge clk);
    addr = 16'h00A8; data_in = 8'hC0; iorq_n = 1'b0; wr_n = 1'b0;
    want(O_PRIM, "prim_pre_edge", 8'h00);
    settle_check();
    @(negedge clk);
    want(O_PRIM, "prim_commit", 8'hC0);
    want(O_CFG,  "cfg_commit",  8'h01);
    settle_check();
    data_in = 8'h3C;
    repeat (4) @(negedge clk);
    want(O_PRIM, "prim_once", 8'hC0);
    settle_check();
    idle();

    // Secondary register write, complemented read-back, page decode
    mem_wr(16'hFFFF, 8'h1B);
    mem_rd(16'hFFFF);
    want(O_DOE,  "ssr_oe",   8'h01);
    want(O_DOUT, "ssr_data", 8'hE4);
    settle_check();
    idle();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      addr = pg_addr[i];
      want(O_SUB, $sformatf("sub_c0_p%0d", i), sub_c0[i]);
      settle_check();
    end
    io_wr(16'h00A8, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      addr = pg_addr[i];
      want(O_SUB, $sformatf("sub_ff_p%0d", i), sub_ff[i]);
      settle_check();
    end

    // Page 3 in an unexpanded slot: FFFFh belongs to RAM
    io_wr(16'h00A8, 8'h00);
    mem_wr(16'hFFFF, 8'h55);
    mem_rd(16'hFFFF);
    want(O_DOE,  "ram_ffff_oe",   8'h00);
    want(O_DOUT, "ram_ffff_data", 8'h00);
    settle_check();
    idle();
    io_wr(16'h00A8, 8'hC0);
    mem_rd(16'hFFFF);
    want(O_DOUT, "sec3_kept", 8'hE4);
    settle_check();
    idle();

    // Interrupt acknowledge neither reads nor writes
    @(negedge clk);
    addr = 16'h00A8; data_in = 8'h12; iorq_n = 1'b0; m1_n = 1'b0; rd_n = 1'b0;
    want(O_DOE, "inta_oe", 8'h00);
    settle_check();
    rd_n = 1'b1; wr_n = 1'b0;
    @(negedge clk);
    idle();
    want(O_PRIM, "inta_prim", 8'hC0);
    settle_check();

    // Illegal iorq+mreq at FFFFh: memory side suppressed
    @(negedge clk);
    addr = 16'hFFFF; data_in = 8'h40; iorq_n = 1'b0; mreq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    idle();
    want(O_PRIM, "illegal_prim", 8'hC0);
    settle_check();
    mem_rd(16'hFFFF);
    want(O_DOUT, "illegal_sec", 8'hE4);
    settle_check();
    idle();

    // Reset during a write; no replay after release
    @(negedge clk);
    addr = 16'h00A8; data_in = 8'h99; iorq_n = 1'b0; wr_n = 1'b0; reset = 1'b1;
    want(O_PRIM, "async_rst_prim", 8'h00);
    want(O_CFG,  "async_rst_cfg",  8'h00);
    settle_check();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    want(O_PRIM, "held_wr_prim", 8'h00);
    want(O_CFG,  "held_wr_cfg",  8'h00);
    settle_check();
    wr_n = 1'b1;
    @(negedge clk);
    data_in = 8'h81; wr_n = 1'b0;
    @(negedge clk);
    idle();
    want(O_PRIM, "rearm_prim", 8'h81);
    want(O_CFG,  "rearm_cfg",  8'h01);
    settle_check();

    // Priority on an instance where FFFFh decodes as both I/O and memory
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    addr = 16'hFFFF; data_in = 8'h40; iorq_n = 1'b0; mreq_n = 1'b0; wr_n = 1'b0;
    @(negedge clk);
    idle();
    want(O_PRIM2, "prio_prim2", 8'h40);
    want(O_PRIM,  "prio_prim",  8'h00);
    settle_check();
    io_wr(16'h00FF, 8'h00);
    want(O_PRIM2, "prio_back_slot0", 8'h00);
    settle_check();
    mem_rd(16'hFFFF);
    want(O_DOE2,  "prio_oe2",   8'h01);
    want(O_DOUT2, "prio_sec0",  8'hFF);
    want(O_DOE,   "prio_oe",    8'h00);
    settle_check();
    idle();

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
